qbus_master: RTL
================

// Module: qbus_master
//
// PURPOSE
//  Synthesizable QBUS bus-master (initiator) for the M4 (am4) board designs. Converts a simple
//  single-word request port into arbitrated, inverted-level QBUS DATI/DATO(B) cycles.
//  Sequence: DMR/DMGI/SACK acquisition, then SYNC/DIN/DOUT strobes, then wait for RPLY.
//  Targets RAM/console responders and DMA-style peripherals as a bus exerciser.
//
// PARAMETERS
//  ASETUP  2     clk cycles the address is driven before SYNC falls (>=1)
//  DSETUP  1     clk cycles after SYNC falls before DIN/DOUT fall; write data driven meanwhile (>=1)
//  TOUT_W  10    width of the RPLY timeout counter
//  TOUT    1000  cycles from DIN/DOUT assertion to bus error if no RPLY (< 2**TOUT_W)
//
// PORTS
//  clk       in   1   system clock
//  reset     in   1   reset: synchronous, active-high
//  req       in   1   transfer request, sampled only in IDLE
//  we        in   1   1=write (DATO/DATOB), 0=read (DATI)
//  bmode     in   1   byte write; addr[0] selects the lane
//  addr      in   16  byte address (true polarity)
//  wdata     in   16  write data (true polarity)
//  ack       out  1   one-cycle pulse: transfer finished (OK or error)
//  err       out  1   valid with ack: RPLY timeout
//  rdata     out  16  read data, valid from ack until next ack
//  busy      out  1   high from accepted req until the cycle after ack
//  ad_in_n   in   16  inverted AD bus, bus side
//  ad_out_n  out  16  inverted AD bus drive value
//  ad_oe     out  1   AD bus output enable
//  sync_n    out  1   address strobe
//  din_n     out  1   data input strobe
//  dout_n    out  1   data output strobe
//  wtbt_n    out  1   write/byte status
//  rply_n    in   1   slave reply, asynchronous
//  dmr_n     out  1   bus request
//  dmgi_n    in   1   bus grant in, asynchronous
//  sack_n    out  1   bus acknowledge
//
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. In reset, and on the first edge
//    after reset asserts (even mid-cycle), all *_n outputs are 1.
//    ad_oe=0, ad_out_n=16'hFFFF, ack=err=busy=0, rdata=0, state=IDLE, no partial ack.
//  - rply_n and dmgi_n pass through 2-flop synchronizers; "rply"/"grant" below mean synced-low.
//  - IDLE: on req, latch we/bmode/addr/wdata, set busy, assert dmr_n=0, go to BREQ.
//  - BREQ: wait for grant (unbounded). Then sack_n=0 and next cycle dmr_n=1. Go to ADDR.
//  - ADDR: ad_oe=1, ad_out_n=~addr, wtbt_n=~we, for ASETUP cycles. Go to SYNC.
//  - SYNC: sync_n=0, held low until END. Address held 1 cycle.
//    Write: ad_out_n=~wdata and wtbt_n=~bmode for DSETUP cycles.
//    Read: ad_oe=0 and wtbt_n=1.
//  - DATA: din_n=0 (read) or dout_n=0 (write). Timeout counter clears on entry.
//    While waiting: on rply, capture rdata=~ad_in_n (read) and go to RACK.
//    Counter==TOUT without rply: set err, go to RACK.
//  - RACK: din_n=dout_n=1 and ad_oe=0 on entry. Wait for rply negated (or exit
//    immediately if err). Bound: TOUT cycles, after which err is set.
//  - END: sync_n=1, wtbt_n=1, sack_n=1, ack=1 for one cycle. busy drops next cycle, back to IDLE.
//  - DIN and DOUT are never low together. DIN/DOUT never fall in the cycle SYNC falls.
//    AD is never driven while DIN is low.
//  - req asserted while busy is ignored. New req in the cycle after ack is accepted.
//  - Minimum latency, req to ack, with immediate grant and rply: 2 sync + 1 grant
//    + ASETUP + DSETUP + 2 rply-sync + 2 negate + 1 END cycles.
//
// TESTING
//  1 DATI: addr=16'o001000, slave returns 16'o123456 after 3 clk ->
//    ack with err=0, rdata=16'o123456, DIN only, wtbt_n=1 throughout.
//  2 DATOB: addr=16'o177567, wdata=16'h0041, bmode=1 ->
//    wtbt_n=0 at SYNC fall, wtbt_n=0 during DOUT, AD=~16'h0041, DIN never low.
//  3 Grant delayed 50 clk ->
//    sync_n stays 1 and ad_oe stays 0 until grant, then the normal cycle.
//  4 No RPLY, TOUT=1000 ->
//    ack with err=1 about 1000 clk after DIN, all strobes/sack_n back to 1, next req serviced.
//  5 reset asserted while DOUT is low ->
//    next edge: all *_n=1, ad_oe=0, no ack. After release, a read completes normally.
//  6 Back-to-back: req held high across 3 reads ->
//    3 ack pulses, SYNC high >=1 cycle between cycles, DMR/SACK cycled each transfer.

Source files
------------

// File: rtl/qbus_master.sv
// QBUS bus master: turns a single-word request into an arbitrated DATI/DATO(B) cycle.
// Bus outputs are registered from the next-state decode, so the strobes are glitch-free.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for req; all bus outputs negated
// BREQ   | DMR asserted, waiting for synchronized grant
// GACK   | SACK asserted, DMR still asserted for one cycle
// ADDR   | address and WTBT driven, DMR released, ASETUP cycles
// SYNA   | SYNC low, address still held for one cycle
// SYND   | SYNC low, write data driven (read: bus released), DSETUP-1 cycles
// DATA   | DIN/DOUT low, waiting for RPLY or timeout
// RACK   | DIN/DOUT high, waiting for RPLY negation or timeout
// END    | SYNC/SACK high, one-cycle ack
module qbus_master #(
    parameter int ASETUP = 2,
    parameter int DSETUP = 1,
    parameter int TOUT_W = 10,
    parameter int TOUT   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        bmode,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic        busy,
    input  logic [15:0] ad_in_n,
    output logic [15:0] ad_out_n,
    output logic        ad_oe,
    output logic        sync_n,
    output logic        din_n,
    output logic        dout_n,
    output logic        wtbt_n,
    input  logic        rply_n,
    output logic        dmr_n,
    input  logic        dmgi_n,
    output logic        sack_n
);

    typedef enum logic [3:0] {
        S_IDLE, S_BREQ, S_GACK, S_ADDR, S_SYNA, S_SYND, S_DATA, S_RACK, S_END
    } state_t;

    localparam logic [TOUT_W-1:0] CNT_ASU = TOUT_W'(ASETUP - 1);
    localparam logic [TOUT_W-1:0] CNT_DSU = TOUT_W'(DSETUP - 2);
    localparam logic [TOUT_W-1:0] CNT_TO  = TOUT_W'(TOUT - 1);

    state_t             state, state_nxt;
    logic [TOUT_W-1:0]  cnt, cnt_nxt;
    logic               err_q, err_nxt;
    logic [15:0]        cap_q, cap_nxt;
    logic               take;
    logic               we_q, bm_q;
    logic [15:0]        addr_q, wdata_q;
    logic               rply_s1, rply_s2, gnt_s1, gnt_s2;
    logic               rply, grant;

    logic               o_ack, o_err, o_busy, o_oe;
    logic [15:0]        o_ad_n;
    logic               o_sync, o_din, o_dout, o_wtbt, o_dmr, o_sack;

    assign rply  = ~rply_s2;
    assign grant = ~gnt_s2;

    // two-flop synchronizers for the asynchronous bus inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rply_s1 <= 1'b1;
            rply_s2 <= 1'b1;
            gnt_s1  <= 1'b1;
            gnt_s2  <= 1'b1;
        end else begin
            rply_s1 <= rply_n;
            rply_s2 <= rply_s1;
            gnt_s1  <= dmgi_n;
            gnt_s2  <= gnt_s1;
        end
    end

    // next-state, timer and capture logic, then output decode of the next state
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_q;
        cap_nxt   = cap_q;
        take      = 1'b0;
        case (state)
            S_IDLE: if (req) begin
                take      = 1'b1;
                err_nxt   = 1'b0;
                state_nxt = S_BREQ;
            end
            S_BREQ: if (grant) state_nxt = S_GACK;
            S_GACK: begin
                state_nxt = S_ADDR;
                cnt_nxt   = CNT_ASU;
            end
            S_ADDR: if (cnt == '0) state_nxt = S_SYNA;
                    else cnt_nxt = cnt - 1'b1;
            S_SYNA: if (DSETUP > 1) begin
                state_nxt = S_SYND;
                cnt_nxt   = CNT_DSU;
            end else begin
                state_nxt = S_DATA;
                cnt_nxt   = CNT_TO;
            end
            S_SYND: if (cnt == '0) begin
                state_nxt = S_DATA;
                cnt_nxt   = CNT_TO;
            end else cnt_nxt = cnt - 1'b1;
            S_DATA: if (rply) begin
                if (!we_q) cap_nxt = ~ad_in_n;
                state_nxt = S_RACK;
                cnt_nxt   = CNT_TO;
            end else if (cnt == '0) begin
                err_nxt   = 1'b1;
                state_nxt = S_RACK;
            end else cnt_nxt = cnt - 1'b1;
            S_RACK: if (err_q || !rply) state_nxt = S_END;
                    else if (cnt == '0) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_END;
                    end else cnt_nxt = cnt - 1'b1;
            S_END:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        o_ack  = 1'b0;
        o_err  = 1'b0;
        o_busy = (state_nxt != S_IDLE);
        o_oe   = 1'b0;
        o_ad_n = 16'hFFFF;
        o_sync = 1'b1;
        o_din  = 1'b1;
        o_dout = 1'b1;
        o_wtbt = 1'b1;
        o_dmr  = 1'b1;
        o_sack = 1'b1;
        case (state_nxt)
            S_BREQ: o_dmr = 1'b0;
            S_GACK: begin
                o_dmr  = 1'b0;
                o_sack = 1'b0;
            end
            S_ADDR, S_SYNA: begin
                o_sack = 1'b0;
                o_sync = (state_nxt != S_SYNA);
                o_oe   = 1'b1;
                o_ad_n = ~addr_q;
                o_wtbt = ~we_q;
            end
            S_SYND, S_DATA: begin
                o_sack = 1'b0;
                o_sync = 1'b0;
                if (we_q) begin
                    o_oe   = 1'b1;
                    o_ad_n = ~wdata_q;
                    o_wtbt = ~bm_q;
                    o_dout = (state_nxt != S_DATA);
                end else begin
                    o_din  = (state_nxt != S_DATA);
                end
            end
            S_RACK: begin
                o_sack = 1'b0;
                o_sync = 1'b0;
                if (we_q) o_wtbt = ~bm_q;
            end
            S_END: begin
                o_ack = 1'b1;
                o_err = err_nxt;
            end
            default: ;
        endcase
    end

    // FSM state, timer and latched request
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            cap_q   <= '0;
            we_q    <= 1'b0;
            bm_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
            cap_q <= cap_nxt;
            if (take) begin
                we_q    <= we;
                bm_q    <= bmode;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    // registered bus and user-side outputs; rdata only moves on a good read
    always_ff @(posedge clk) begin
        if (reset) begin
            ack      <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            rdata    <= '0;
            ad_oe    <= 1'b0;
            ad_out_n <= 16'hFFFF;
            sync_n   <= 1'b1;
            din_n    <= 1'b1;
            dout_n   <= 1'b1;
            wtbt_n   <= 1'b1;
            dmr_n    <= 1'b1;
            sack_n   <= 1'b1;
        end else begin
            ack      <= o_ack;
            err      <= o_err;
            busy     <= o_busy;
            ad_oe    <= o_oe;
            ad_out_n <= o_ad_n;
            sync_n   <= o_sync;
            din_n    <= o_din;
            dout_n   <= o_dout;
            wtbt_n   <= o_wtbt;
            dmr_n    <= o_dmr;
            sack_n   <= o_sack;
            if (state_nxt == S_END && !err_nxt && !we_q) rdata <= cap_q;
        end
    end

endmodule
